// File: rtl/ram_hs.sv
`default_nettype none
// ============================================================================
//  Module      : ram_hs
//  Description : Single-port on-chip RAM with valid/ready request/response
//                handshake, configurable read latency, byte-strobed writes,
//                base-address decode and optional zero-clear after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_hs #(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 32,
    parameter int                DEPTH_WORDS    = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h8000_0000,
    parameter int                LATENCY        = 1,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                init_done
);

    localparam int c_NBYTES = DATA_W / 8;
    localparam int c_LSB    = $clog2(c_NBYTES);
    localparam int c_IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int c_CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [ADDR_W-1:0]  c_DEPTH_A = ADDR_W'(DEPTH_WORDS);
    localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(DEPTH_WORDS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INI = c_CNT_W'(LATENCY - 1);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_clear_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_resp_valid;
    logic [DATA_W-1:0]  r_resp_rdata;
    logic               r_resp_err;
    logic               r_init_done;
    logic [DATA_W-1:0]  r_mem [DEPTH_WORDS];

    logic [ADDR_W-1:0]  w_offset;
    logic [ADDR_W-1:0]  w_word;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_misaligned;
    logic               w_range_err;
    logic               w_err;
    logic               w_accept;

    // Subtraction wraps, so addresses below the base land far out of range.
    assign w_offset    = req_addr - BASE_ADDR;
    assign w_word      = w_offset >> c_LSB;
    assign w_idx       = w_word[c_IDX_W-1:0];
    assign w_range_err = (w_word >= c_DEPTH_A);
    assign w_err       = w_misaligned || w_range_err;
    assign w_accept    = req_valid && req_ready;

    generate
        if (c_LSB > 0) begin : g_align
            assign w_misaligned = |w_offset[c_LSB-1:0];
        end else begin : g_noalign
            assign w_misaligned = 1'b0;
        end
    endgenerate

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign init_done  = r_init_done;

    // Array port: clear sweep or strobed write; contents survive reset.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_clear_idx] <= '0;
        end else if (w_accept && req_wen && !w_err) begin
            for (int b = 0; b < c_NBYTES; b++) begin
                if (req_wstrb[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= CLEAR_ON_RESET ? S_INIT : S_IDLE;
            r_clear_idx  <= '0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_init_done  <= !CLEAR_ON_RESET;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_clear_idx <= r_clear_idx + 1'b1;
                    if (r_clear_idx == c_LAST) begin
                        r_clear_idx <= '0;
                        r_state     <= S_IDLE;
                        r_init_done <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        r_resp_err   <= w_err;
                        r_resp_rdata <= (w_err || req_wen) ? '0 : r_mem[w_idx];
                        if (LATENCY == 1) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_CNT_INI;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
